uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer between the UART receive shift register and the host-side RBR/LSR read logic, controlled by the FIFO control register outputs (FIFOEN, RXCLR, RXFIFTL). Stores received characters with per-character parity, framing and break status. Generates data-ready, trigger-level, overrun, error-in-FIFO and character-timeout indications. Runs as a 16-entry FIFO when FIFOs are enabled, and as a single holding register when they are disabled.

## Interface
- DEPTH, 16, FIFO entries in FIFO mode; power of two.
- TOUT_TICKS, 640, baud_tick pulses without FIFO activity before timeout (4 chars × 10 bits × 16).
- m_clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clock m_clk.
- fifoen  in  1  FIFO mode enable (FCR bit 0).
- rxclr  in  1  RX clear request (FCR bit 1).
- rxfiftl  in  2  trigger level select (FCR bits 4:3).
- wr_en  in  1  one-cycle strobe: character complete from the shift register.
- wr_data  in  8  received character.
- wr_pe, wr_fe, wr_bi  in  1 each  parity error, framing error and break status for wr_data.
- rd_en  in  1  one-cycle strobe: host read of RBR.
- ov_clr  in  1  one-cycle strobe: host read of LSR; clears overrun.
- baud_tick  in  1  16× baud enable pulse.
- rd_data  out  8  head character (show-ahead).
- rd_pe, rd_fe, rd_bi  out  1 each  status bits of the head character.
- count  out  5  number of stored entries, 0..DEPTH.
- empty, full  out  1 each  occupancy flags; full uses the effective depth.
- data_ready  out  1  equal to !empty (LSR bit 0).
- overrun  out  1  sticky overrun flag (LSR bit 1).
- trig  out  1  trigger level reached.
- fifo_err  out  1  at least one stored entry has PE, FE or BI set (LSR bit 7).
- timeout  out  1  character timeout indication.

## Operation
- **Effective depth:** DEPTH when fifoen=1; 1 when fifoen=0.
- **Storage:** 11-bit entries {bi,fe,pe,data}, circular read and write pointers, wrap modulo DEPTH.
- **Write:** wr_en with count < effective depth stores the entry at the write pointer and increments count.
- **Read:** rd_en with count > 0 advances the read pointer and decrements count. rd_en when empty is ignored; rd_data holds its value.
- **Simultaneous read and write:**
  - Non-empty: both are performed; count is unchanged.
  - Full: the read frees a slot, so the write is accepted and no overrun occurs.
- **Overrun:** wr_en while full with no rd_en.
  - FIFO mode: the new character is discarded; contents are unchanged.
  - Non-FIFO mode: the holding register is overwritten with the new character.
  - In both modes overrun is set and stays set until ov_clr.
  - ov_clr and a new overrun in the same cycle: overrun stays 1.
- **Clear:** a clear occurs when rxclr rises from 0 to 1 (edge detected against a registered copy), or when fifoen changes value.
  - Clear sets pointers, count and the error counter to 0 and deasserts timeout.
  - Clear does not reset overrun.
  - wr_en and rd_en in the clear cycle are ignored.
- **Error tracking:** a counter holds the number of stored entries with any status bit set. It increments when such an entry is written and decrements when such an entry is read. fifo_err = (counter != 0) && fifoen.
- **Trigger level:** rxfiftl 00→1, 01→4, 10→8, 11→14. trig = fifoen && count >= level. trig = 0 when fifoen=0.

## Timing
- Reset values:
  - count=0, empty=1, full=0, data_ready=0.
  - overrun=0, trig=0, fifo_err=0, timeout=0.
  - rd_data=0 and rd_pe/rd_fe/rd_bi=0.
  - Pointers and the rxclr edge register are 0.
- Reset has priority over clear, and clear has priority over read/write.
- Write in cycle N: rd_data, empty, count, trig and fifo_err reflect it from cycle N+1.
- Read in cycle N: the next entry appears on rd_data in cycle N+1.
- rxclr rising sampled in cycle N: empty=1 from cycle N+1.
- Reset asserted mid-stream: all state returns to reset values on the next edge; no partial entry is retained.

## Configuration
- RX_TIMEOUT_EN defined:
  - A counter of baud_tick pulses is reset on any accepted write, any accepted read, or a clear.
  - Counting proceeds only while fifoen=1 and count > 0.
  - When the counter reaches TOUT_TICKS, timeout is set. It stays set until the next read, write or clear, or until count becomes 0.
- RX_TIMEOUT_EN undefined: the counter is not built and timeout is tied to 0.

## Test plan
- fifoen=1, rxfiftl=01: write 0x41,0x42,0x43 → trig=0, count=3. Write 0x44 → trig=1 next cycle, rd_data=0x41.
- fifoen=1: write 16 characters, then a 17th (0xAA) → overrun=1, count=16, and 16 reads return the original 16 characters in order. Pulse ov_clr → overrun=0.
- fifoen=0: write 0x11, then 0x22 with no read → overrun=1, rd_data=0x22, count=1, trig=0.
- fifoen=1: write 0x55 with wr_fe=1, then 0x66 clean → fifo_err=1. Read once → fifo_err=0, rd_data=0x66.
- fifoen=1, count=5: raise rxclr → empty=1, count=0 next cycle. Hold rxclr high and write 0x77 → accepted, count=1 (no repeat clear).
- RX_TIMEOUT_EN, fifoen=1: write one character, then issue 640 baud_tick pulses with no reads → timeout=1. One read → timeout=0, empty=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: 16-entry FIFO (or single holding register when FIFOs are off)
// with per-character PE/FE/BI status. Optional character timeout: define RX_TIMEOUT_EN.
module uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int TOUT_TICKS = 640
) (
  input  logic       m_clk,
  input  logic       reset,
  input  logic       fifoen,
  input  logic       rxclr,
  input  logic [1:0] rxfiftl,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       wr_pe,
  input  logic       wr_fe,
  input  logic       wr_bi,
  input  logic       rd_en,
  input  logic       ov_clr,
  input  logic       baud_tick,
  output logic [7:0] rd_data,
  output logic       rd_pe,
  output logic       rd_fe,
  output logic       rd_bi,
  output logic [4:0] count,
  output logic       empty,
  output logic       full,
  output logic       data_ready,
  output logic       overrun,
  output logic       trig,
  output logic       fifo_err,
  output logic       timeout
);
  localparam int AW = $clog2(DEPTH);

  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [4:0]    cnt, err_cnt, eff_depth, level;
  logic          rxclr_p1, fifoen_p1;
  logic          clr, is_full, rd_acc, wr_acc, ovw, ovr_set, new_err, head_err;
  logic [10:0]   head, entry;

  assign head      = mem[rptr];
  assign entry     = {wr_bi, wr_fe, wr_pe, wr_data};
  assign new_err   = wr_bi | wr_fe | wr_pe;
  assign head_err  = |head[10:8];
  assign eff_depth = fifoen ? 5'(DEPTH) : 5'd1;
  assign is_full   = cnt >= eff_depth;

  // A clear swallows any read/write strobe arriving in the same cycle.
  assign clr     = (rxclr & ~rxclr_p1) | (fifoen ^ fifoen_p1);
  assign rd_acc  = rd_en && (cnt != 5'd0) && !clr;
  assign wr_acc  = wr_en && (!is_full || rd_acc) && !clr;
  assign ovr_set = wr_en && is_full && !rd_en && !clr;
  // Non-FIFO mode overwrites the holding register in place on overrun.
  assign ovw     = ovr_set && !fifoen;

  always_ff @(posedge m_clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      err_cnt   <= '0;
      overrun   <= 1'b0;
      rxclr_p1  <= 1'b0;
      fifoen_p1 <= fifoen;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rxclr_p1  <= rxclr;
      fifoen_p1 <= fifoen;
      if (ovr_set)     overrun <= 1'b1;
      else if (ov_clr) overrun <= 1'b0;
      if (clr) begin
        wptr    <= '0;
        rptr    <= '0;
        cnt     <= '0;
        err_cnt <= '0;
      end else begin
        if (wr_acc) begin
          mem[wptr] <= entry;
          wptr      <= wptr + 1'b1;
        end
        if (ovw)    mem[rptr] <= entry;
        if (rd_acc) rptr <= rptr + 1'b1;
        cnt     <= cnt + 5'(wr_acc) - 5'(rd_acc);
        err_cnt <= err_cnt + 5'((wr_acc || ovw) && new_err)
                           - 5'((rd_acc || ovw) && head_err);
      end
    end
  end

  always_comb begin
    level = 5'd1;
    case (rxfiftl)
      2'b00:   level = 5'd1;
      2'b01:   level = 5'd4;
      2'b10:   level = 5'd8;
      default: level = 5'd14;
    endcase
  end

  assign rd_data    = head[7:0];
  assign rd_pe      = head[8];
  assign rd_fe      = head[9];
  assign rd_bi      = head[10];
  assign count      = cnt;
  assign empty      = (cnt == 5'd0);
  assign full       = is_full;
  assign data_ready = !empty;
  assign trig       = fifoen && (cnt >= level);
  assign fifo_err   = fifoen && (err_cnt != 5'd0);

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TOUT_TICKS + 1);
  logic [TW-1:0] tcnt;
  logic          tout;

  // Any FIFO activity, clear, or an empty/disabled FIFO restarts the idle count.
  always_ff @(posedge m_clk) begin
    if (reset || clr || wr_acc || rd_acc || ovw || !fifoen || cnt == 5'd0) begin
      tcnt <= '0;
      tout <= 1'b0;
    end else if (baud_tick && tcnt != TW'(TOUT_TICKS)) begin
      tcnt <= tcnt + 1'b1;
      if (tcnt == TW'(TOUT_TICKS - 1)) tout <= 1'b1;
    end
  end
  assign timeout = tout;
`else
  logic unused_tout;
  assign unused_tout = baud_tick & (TOUT_TICKS != 0);
  assign timeout     = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: written characters are queued and compared
// against the show-ahead head as they are read back.
module tb_uart_rx_fifo;
  logic       m_clk = 1'b0;
  logic       reset, fifoen, rxclr, wr_en, wr_pe, wr_fe, wr_bi, rd_en, ov_clr, baud_tick;
  logic [1:0] rxfiftl;
  logic [7:0] wr_data, rd_data;
  logic       rd_pe, rd_fe, rd_bi, empty, full, data_ready, overrun, trig, fifo_err, timeout;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] orig[16];

  uart_rx_fifo dut (
    .m_clk(m_clk), .reset(reset), .fifoen(fifoen), .rxclr(rxclr), .rxfiftl(rxfiftl),
    .wr_en(wr_en), .wr_data(wr_data), .wr_pe(wr_pe), .wr_fe(wr_fe), .wr_bi(wr_bi),
    .rd_en(rd_en), .ov_clr(ov_clr), .baud_tick(baud_tick),
    .rd_data(rd_data), .rd_pe(rd_pe), .rd_fe(rd_fe), .rd_bi(rd_bi), .count(count),
    .empty(empty), .full(full), .data_ready(data_ready), .overrun(overrun),
    .trig(trig), .fifo_err(fifo_err), .timeout(timeout)
  );

  always #5 m_clk = ~m_clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge m_clk);
    #1;
    wr_en = 0; rd_en = 0; ov_clr = 0; baud_tick = 0;
    wr_pe = 0; wr_fe = 0; wr_bi = 0;
  endtask

  task automatic write(input logic [7:0] d, input logic fe = 1'b0);
    wr_en = 1; wr_data = d; wr_fe = fe;
    step();
  endtask

  task automatic read();
    logic [7:0] exp;
    if (sb.size() == 0) begin
      chk("sb_underflow", 16'd1, 16'd0);
      exp = 8'h00;
    end else exp = sb.pop_front();
    chk("rd_data", {8'h0, rd_data}, {8'h0, exp});
    rd_en = 1;
    step();
  endtask

  task automatic drain();
    while (sb.size() != 0) read();
    chk("empty_after_drain", {15'h0, empty}, 16'd1);
  endtask

  initial begin
    reset = 1; fifoen = 1; rxclr = 0; rxfiftl = 2'b00;
    wr_en = 0; wr_data = 0; wr_pe = 0; wr_fe = 0; wr_bi = 0;
    rd_en = 0; ov_clr = 0; baud_tick = 0;
    repeat (2) @(posedge m_clk);
    #1 reset = 0;

    // reset state
    chk("rst_count", {11'h0, count}, 16'd0);
    chk("rst_flags", {8'h0, empty, full, data_ready, overrun, trig, fifo_err, timeout, 1'b0}, 16'h80);
    chk("rst_head", {5'h0, rd_bi, rd_fe, rd_pe, rd_data}, 16'd0);

    // trigger level 4
    rxfiftl = 2'b01;
    foreach (sb[i]) ;
    write(8'h41); sb.push_back(8'h41);
    write(8'h42); sb.push_back(8'h42);
    write(8'h43); sb.push_back(8'h43);
    chk("trig_below", {15'h0, trig}, 16'd0);
    chk("count3", {11'h0, count}, 16'd3);
    write(8'h44); sb.push_back(8'h44);
    chk("trig_at", {15'h0, trig}, 16'd1);
    chk("head41", {8'h0, rd_data}, 16'h41);
    drain();
    chk("trig_empty", {15'h0, trig}, 16'd0);

    // FIFO-mode overrun discards the new character
    for (int i = 0; i < 16; i++) begin
      orig[i] = 8'(i * 13 + 7);
      write(orig[i]); sb.push_back(orig[i]);
    end
    chk("full16", {15'h0, full}, 16'd1);
    write(8'hAA);
    chk("ovr_set", {15'h0, overrun}, 16'd1);
    chk("ovr_count", {11'h0, count}, 16'd16);
    drain();
    chk("ovr_sticky", {15'h0, overrun}, 16'd1);
    ov_clr = 1; step();
    chk("ovr_clr", {15'h0, overrun}, 16'd0);

    // holding-register mode: overrun overwrites
    fifoen = 0; step();
    write(8'h11);
    write(8'h22); sb.push_back(8'h22);
    chk("nf_ovr", {15'h0, overrun}, 16'd1);
    chk("nf_head", {8'h0, rd_data}, 16'h22);
    chk("nf_count", {11'h0, count}, 16'd1);
    chk("nf_trig", {15'h0, trig}, 16'd0);
    chk("nf_full", {15'h0, full}, 16'd1);
    drain();
    ov_clr = 1; write(8'h33);
    chk("ovr_same_cycle", {15'h0, overrun}, 16'd0);
    sb.push_back(8'h33);
    drain();

    // error tracking
    fifoen = 1; step();
    chk("mode_clear", {11'h0, count}, 16'd0);
    write(8'h55, 1'b1); sb.push_back(8'h55);
    write(8'h66);       sb.push_back(8'h66);
    chk("fifo_err_set", {15'h0, fifo_err}, 16'd1);
    chk("head_fe", {15'h0, rd_fe}, 16'd1);
    read();
    chk("fifo_err_clr", {15'h0, fifo_err}, 16'd0);
    chk("head66", {8'h0, rd_data}, 16'h66);
    drain();

    // clear on rxclr edge only
    for (int i = 0; i < 5; i++) write(8'(8'h90 + i));
    chk("count5", {11'h0, count}, 16'd5);
    rxclr = 1; wr_en = 1; wr_data = 8'hEE; step();
    chk("clr_empty", {15'h0, empty}, 16'd1);
    chk("clr_count", {11'h0, count}, 16'd0);
    write(8'h77); sb.push_back(8'h77);
    chk("clr_held", {11'h0, count}, 16'd1);
    rxclr = 0;
    drain();

    // simultaneous read/write while full
    for (int i = 0; i < 16; i++) begin
      write(8'(8'hC0 + i)); sb.push_back(8'(8'hC0 + i));
    end
    chk("sim_head", {8'h0, rd_data}, 16'hC0);
    void'(sb.pop_front());
    rd_en = 1; wr_en = 1; wr_data = 8'hBB; step(); sb.push_back(8'hBB);
    chk("sim_count", {11'h0, count}, 16'd16);
    chk("sim_no_ovr", {15'h0, overrun}, 16'd0);
    drain();

    // character timeout
    write(8'h5A); sb.push_back(8'h5A);
    repeat (639) begin baud_tick = 1; step(); end
    chk("tout_early", {15'h0, timeout}, 16'd0);
    baud_tick = 1; step();
`ifdef RX_TIMEOUT_EN
    chk("tout_set", {15'h0, timeout}, 16'd1);
`else
    chk("tout_off", {15'h0, timeout}, 16'd0);
`endif
    read();
    chk("tout_clr", {15'h0, timeout}, 16'd0);
    chk("tout_empty", {15'h0, empty}, 16'd1);

    // reset mid-stream
    write(8'h01, 1'b1); write(8'h02); write(8'h03);
    wr_en = 1; wr_data = 8'h04; reset = 1; step();
    reset = 0;
    chk("mid_rst_count", {11'h0, count}, 16'd0);
    chk("mid_rst_head", {5'h0, rd_bi, rd_fe, rd_pe, rd_data}, 16'd0);
    chk("mid_rst_err", {15'h0, fifo_err}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
